// File: rtl/changebit_apb_ctrl.sv
// changebit_apb_ctrl: APB slave sequencing one changebit datapath (drive, settle, capture, status/irq).
// Revision 1.0
`default_nettype none

module changebit_apb_ctrl #(
  parameter int BITS   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic [BITS-1:0]   o_argA,
  output logic [BITS-1:0]   o_argB,
  input  logic [BITS-1:0]   i_result,
  input  logic              i_error,
  output logic              o_irq
);

  localparam logic [ADDR_W-1:0] ADDR_ARGA   = ADDR_W'(5'h00);
  localparam logic [ADDR_W-1:0] ADDR_ARGB   = ADDR_W'(5'h04);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(5'h08);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(5'h0C);
  localparam logic [ADDR_W-1:0] ADDR_RESULT = ADDR_W'(5'h10);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   arga_q, arga_d;
  logic [BITS-1:0]   argb_q, argb_d;
  logic [BITS-1:0]   oarga_q, oarga_d;
  logic [BITS-1:0]   oargb_q, oargb_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              irq_q;

  logic w_xfer, w_wr, w_rd, w_busy, w_mapped, w_start;
  logic hit_arga, hit_argb, hit_ctrl, hit_status, hit_result;
  logic w_unused;

  assign w_xfer     = i_psel & i_penable;
  assign w_wr       = w_xfer & i_pwrite;
  assign w_rd       = w_xfer & ~i_pwrite;
  assign w_busy     = (state_q != S_IDLE);
  assign hit_arga   = (i_paddr == ADDR_ARGA);
  assign hit_argb   = (i_paddr == ADDR_ARGB);
  assign hit_ctrl   = (i_paddr == ADDR_CTRL);
  assign hit_status = (i_paddr == ADDR_STATUS);
  assign hit_result = (i_paddr == ADDR_RESULT);
  assign w_mapped   = hit_arga | hit_argb | hit_ctrl | hit_status | hit_result;
  assign w_start    = w_wr & hit_ctrl & i_pwdata[0] & ~w_busy;
  assign w_unused   = ^{1'b0, i_pwdata};

  always_comb begin
    o_prdata  = '0;
    o_pslverr = 1'b0;
    if (w_xfer) begin
      if (!w_mapped) begin
        o_pslverr = 1'b1;
      end else if (i_pwrite) begin
        o_pslverr = hit_status | hit_result | ((hit_arga | hit_argb) & w_busy) |
                    (hit_ctrl & i_pwdata[0] & w_busy);
      end else begin
        if (hit_arga)   o_prdata = DATA_W'(arga_q);
        if (hit_argb)   o_prdata = DATA_W'(argb_q);
        if (hit_ctrl)   o_prdata = DATA_W'({irq_en_q, 1'b0});
        if (hit_status) o_prdata = DATA_W'({err_q, done_q, w_busy});
        if (hit_result) o_prdata = DATA_W'(result_q);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    oarga_d  = oarga_q;
    oargb_d  = oargb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;

    if (w_wr && hit_arga && !w_busy) arga_d = i_pwdata[BITS-1:0];
    if (w_wr && hit_argb && !w_busy) argb_d = i_pwdata[BITS-1:0];
    if (w_wr && hit_ctrl)            irq_en_d = i_pwdata[1];
    if (w_rd && hit_status) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    // The capture assignments come last so they win over a coincident STATUS-read clear.
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d = S_DRIVE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_DRIVE: begin
        oarga_d = arga_q;
        oargb_d = argb_q;
        cnt_d   = CNT_W'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        result_d = i_result;
        err_d    = i_error;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      arga_q   <= '0;
      argb_q   <= '0;
      oarga_q  <= '0;
      oargb_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      oarga_q  <= oarga_d;
      oargb_q  <= oargb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= done_d & irq_en_d;
    end
  end

  assign o_pready = 1'b1;
  assign o_argA   = oarga_q;
  assign o_argB   = oargb_q;
  assign o_irq    = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_changebit_apb_ctrl.sv
// tb_changebit_apb_ctrl: randomized self-checking bench for changebit_apb_ctrl with a changebit datapath stub.
// Revision 1.0
`default_nettype none

module tb_changebit_apb_ctrl;
  localparam int BITS = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LAT = 2;

  logic              clk, rst_n;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;
  logic [BITS-1:0]   argA, argB, dp_result;
  logic              dp_error, irq;

  int n_checks = 0;
  int n_fail = 0;
  logic [BITS-1:0] last_result = '0;

  changebit_apb_ctrl #(.BITS(BITS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
    .o_pslverr(pslverr), .o_argA(argA), .o_argB(argB), .i_result(dp_result),
    .i_error(dp_error), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: toggle bit argB of argA; out-of-range index flags error and returns ~argA.
  always_comb begin
    dp_result = ~argA;
    dp_error  = 1'b1;
    if (argB < 4'(BITS)) begin
      dp_result = argA ^ (4'b0001 << argB);
      dp_error  = 1'b0;
    end
  end

  function automatic void model_op(input logic [3:0] a, input logic [3:0] b,
                                   output logic [3:0] r, output logic e);
    r = a;
    e = 1'b0;
    if (int'(b) < BITS) r[b[1:0]] = ~a[b[1:0]];
    else begin
      r = ~a;
      e = 1'b1;
    end
  endfunction

  // Bus drivers: called at a negedge, return at the negedge after the transfer edge.
  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, e1, e2, e3;
    #1;
    n_checks++;
    if ({argA, argB, irq, pslverr, prdata} !== '0 || pready !== 1'b1) begin
      n_fail++; $display("FAIL reset_outputs got=%h/%h/%b/%b/%h/%b exp=0 pready=1", argA, argB, irq, pslverr, prdata, pready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      apb_read(5'(i * 4), d, e);
      n_checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h err=%b exp=0", i, d, e);
      end
    end
    apb_write(5'h00, 32'h5, e1); apb_write(5'h04, 32'h1, e2); apb_write(5'h08, 32'h1, e3);
    @(posedge clk); #1;
    n_checks++;
    if (argA !== 4'h5) begin n_fail++; $display("FAIL reset_predrive got=%h exp=5", argA); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if ({argA, argB, irq, pslverr, prdata} !== '0) begin
      n_fail++; $display("FAIL reset_midwait got=%h/%h/%b/%b/%h exp=0", argA, argB, irq, pslverr, prdata);
    end
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(LAT + 4);
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e1, e2, e3, e;
    apb_write(5'h00, 32'h1, e1); apb_write(5'h04, 32'h2, e2); apb_write(5'h08, 32'h1, e3);
    n_checks++;
    if ({e1, e2, e3} !== 3'b000) begin n_fail++; $display("FAIL basic_wr_err got=%b exp=000", {e1, e2, e3}); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL basic_busy got=%h exp=1", d); end
    wait_cyc(LAT + 4);
    n_checks++;
    if (argA !== 4'h1 || argB !== 4'h2) begin n_fail++; $display("FAIL basic_args got=%h/%h exp=1/2", argA, argB); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL basic_done got=%h exp=2", d); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL basic_result got=%h exp=5", d); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL basic_status_clear got=%h exp=0", d); end
    apb_read(5'h08, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL basic_ctrl_read got=%h exp=0", d); end
    last_result = 4'h5;
  endtask

  // A STATUS read whose access phase falls in the capture cycle sees pre-capture values,
  // yet DONE must still be set afterwards.
  task automatic test_capture_collision();
    logic [31:0] d; logic e1, e2, e3, e;
    apb_write(5'h00, 32'h8, e1); apb_write(5'h04, 32'h1, e2); apb_write(5'h08, 32'h1, e3);
    wait_cyc(LAT);
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL collide_pre got=%h exp=1", d); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL collide_post got=%h exp=2", d); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL collide_clear got=%h exp=0", d); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL collide_result got=%h exp=a", d); end
    last_result = 4'hA;
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [27:0] junk);
    logic [31:0] d; logic e1, e2, e3, e, exp_e; logic [3:0] exp_r;
    model_op(a, b, exp_r, exp_e);
    apb_write(5'h00, {junk, a}, e1); apb_write(5'h04, {junk, b}, e2); apb_write(5'h08, 32'h1, e3);
    n_checks++;
    if ({e1, e2, e3} !== 3'b000) begin n_fail++; $display("FAIL %s_wr_err got=%b exp=000", tag, {e1, e2, e3}); end
    wait_cyc(LAT + 4);
    n_checks++;
    if (argA !== a || argB !== b) begin n_fail++; $display("FAIL %s_args got=%h/%h exp=%h/%h", tag, argA, argB, a, b); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== {29'h0, exp_e, 2'b10}) begin n_fail++; $display("FAIL %s_status got=%h exp=%h", tag, d, {29'h0, exp_e, 2'b10}); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== {28'h0, exp_r}) begin n_fail++; $display("FAIL %s_result a=%h b=%h got=%h exp=%h", tag, a, b, d, exp_r); end
    apb_read(5'h00, d, e);
    n_checks++;
    if (d !== {28'h0, a}) begin n_fail++; $display("FAIL %s_arga_rd got=%h exp=%h", tag, d, a); end
    last_result = exp_r;
  endtask

  task automatic test_sequence();
    run_op("seq0", 4'b1000, 4'd1, 28'h0);
    run_op("seq1", 4'b0101, 4'd4, 28'h0);
    run_op("seq2", 4'b1111, 4'd0, 28'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)), 28'($urandom));
  endtask

  task automatic test_busy();
    logic [31:0] d; logic e1, e2, e3, e;
    apb_write(5'h00, 32'h3, e1); apb_write(5'h04, 32'h0, e2); apb_write(5'h08, 32'h1, e3);
    apb_write(5'h00, 32'hF, e1);
    n_checks++;
    if (e1 !== 1'b1) begin n_fail++; $display("FAIL busy_arga_err got=%b exp=1", e1); end
    apb_write(5'h08, 32'h3, e2);
    n_checks++;
    if (e2 !== 1'b1) begin n_fail++; $display("FAIL busy_start_err got=%b exp=1", e2); end
    wait_cyc(LAT + 2);
    n_checks++;
    if (argA !== 4'h3 || irq !== 1'b1) begin n_fail++; $display("FAIL busy_arga_irq got=%h/%b exp=3/1", argA, irq); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL busy_done got=%h exp=2", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL busy_irq_clear got=%b exp=0", irq); end
    apb_read(5'h00, d, e);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL busy_arga_reg got=%h exp=3", d); end
    apb_read(5'h08, d, e);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL busy_irq_en got=%h exp=2", d); end
    wait_cyc(LAT + 4);
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL busy_single_done got=%h exp=0", d); end
    apb_write(5'h08, 32'h0, e);
    last_result = 4'h2;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    apb_read(5'h14, d, e);
    n_checks++;
    if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL err_unmapped14 got=%b/%h exp=1/0", e, d); end
    apb_read(5'h1C, d, e);
    n_checks++;
    if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL err_unmapped1c got=%b/%h exp=1/0", e, d); end
    apb_write(5'h10, 32'hF, e);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_result got=%b exp=1", e); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== {28'h0, last_result} || e !== 1'b0) begin n_fail++; $display("FAIL err_result_kept got=%h exp=%h", d, last_result); end
    apb_write(5'h0C, 32'h7, e);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_status got=%b exp=1", e); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL err_status_kept got=%h exp=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic e1, e2, e3, e; int k; int seen;
    apb_write(5'h00, 32'h2, e1); apb_write(5'h04, 32'h3, e2); apb_write(5'h08, 32'h3, e3);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin k = i; break; end
    end
    n_checks++;
    if (k !== LAT + 2) begin n_fail++; $display("FAIL irq_latency got=%0d exp=%0d", k, LAT + 2); end
    @(negedge clk);
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h2 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%h/%b exp=2/0", d, irq); end
    apb_write(5'h08, 32'h1, e);
    seen = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL irq_disabled got=%0d exp=0", seen); end
    apb_read(5'h0C, d, e);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL irq_dis_done got=%h exp=2", d); end
    apb_read(5'h10, d, e);
    n_checks++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL irq_result got=%h exp=a", d); end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    test_reset();
    test_basic();
    test_capture_collision();
    test_sequence();
    test_busy();
    test_errors();
    test_irq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
